// File: rtl/eth_avl_bridge_pkg.sv
// Shared types and constants for the Ethernet Avalon-MM pipeline bridge.
// Command field widths are fixed here; the bridge top checks its parameters against them.
package eth_avl_bridge_pkg;

    localparam int unsigned PEND_W      = 16;
    localparam int unsigned AVL_ADDR_W  = 32;
    localparam int unsigned AVL_DATA_W  = 64;
    localparam int unsigned AVL_BURST_W = 8;
    localparam int unsigned AVL_BE_W    = AVL_DATA_W / 8;

    typedef struct packed {
        logic                   rd;
        logic                   wr;
        logic [AVL_ADDR_W-1:0]  addr;
        logic [AVL_BE_W-1:0]    byteen;
        logic [AVL_BURST_W-1:0] burst_cnt;
        logic [AVL_DATA_W-1:0]  wrdata;
    } avl_cmd_t;

    // A burst count of zero still moves one beat.
    function automatic logic [PEND_W-1:0] eff_burst(input logic [AVL_BURST_W-1:0] burst);
        return (burst == '0) ? PEND_W'(1) : PEND_W'(burst);
    endfunction

endpackage

// File: rtl/eth_avl_pipe_bridge_if.sv
// Avalon-MM link between the exported DMA slave port, the bridge and the internal bus.
// The master modport issues commands; the slave modport accepts them and returns read data.
interface eth_avl_pipe_bridge_if #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 64,
    parameter int unsigned BURST_W = 8
);
    localparam int unsigned BE_W = DATA_W / 8;

    logic [ADDR_W-1:0]  addr;
    logic [BE_W-1:0]    byteen;
    logic [BURST_W-1:0] burst_cnt;
    logic               rdena;
    logic               wrena;
    logic [DATA_W-1:0]  wrdata;
    logic               wrq;
    logic [DATA_W-1:0]  rddata;
    logic               rddataval;

    modport master (
        output addr, byteen, burst_cnt, rdena, wrena, wrdata,
        input  wrq, rddata, rddataval
    );

    modport slave (
        input  addr, byteen, burst_cnt, rdena, wrena, wrdata,
        output wrq, rddata, rddataval
    );

endinterface

// File: rtl/eth_avl_skid_buf.sv
// Two-entry valid/ready skid buffer. in_ready comes straight from a flop, so the
// upstream stall never depends combinationally on out_ready.
module eth_avl_skid_buf
    import eth_avl_bridge_pkg::*;
#(
    parameter type entry_t = avl_cmd_t
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   in_valid,
    output logic   in_ready,
    input  entry_t in_data,
    output logic   out_valid,
    input  logic   out_ready,
    output entry_t out_data
);

    entry_t     mem_q [2];
    logic       wr_ptr_q;
    logic       rd_ptr_q;
    logic [1:0] cnt_q;
    logic [1:0] cnt_d;
    logic       full_q;
    logic       push;
    logic       pop;

    assign in_ready  = ~full_q;
    assign out_valid = (cnt_q != 2'd0);
    assign out_data  = mem_q[rd_ptr_q];
    assign push      = in_valid & ~full_q;
    assign pop       = out_valid & out_ready;

    always_comb begin
        cnt_d = cnt_q;
        if (push && !pop) begin
            cnt_d = cnt_q + 2'd1;
        end else if (pop && !push) begin
            cnt_d = cnt_q - 2'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
            full_q   <= 1'b0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= in_data;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            cnt_q  <= cnt_d;
            full_q <= (cnt_d == 2'd2);
        end
    end

endmodule

// File: rtl/eth_avl_pipe_bridge.sv
// Registered Avalon-MM pipeline bridge with a burst-aware outstanding-read limiter.
// Define ETH_AVL_BRIDGE_RSP_REG_EN to register the read response path (+1 cycle).
module eth_avl_pipe_bridge
    import eth_avl_bridge_pkg::*;
#(
    parameter int unsigned pADDR_WIDTH  = AVL_ADDR_W,
    parameter int unsigned pDATA_WIDTH  = AVL_DATA_W,
    parameter int unsigned pBURST_WIDTH = AVL_BURST_W,
    parameter int unsigned pMAX_PEND    = 64
) (
    input  logic                 avl_clock,
    input  logic                 avl_rst,
    eth_avl_pipe_bridge_if.slave  s_avl,
    eth_avl_pipe_bridge_if.master m_avl,
    output logic [PEND_W-1:0]    pend_cnt,
    output logic                 err_underflow
);

    if (pADDR_WIDTH != AVL_ADDR_W || pDATA_WIDTH != AVL_DATA_W ||
        pBURST_WIDTH != AVL_BURST_W || (pDATA_WIDTH % 8) != 0 ||
        pMAX_PEND < 1 || pMAX_PEND > 65535) begin : g_bad_cfg
        $error("eth_avl_pipe_bridge: unsupported parameter combination");
    end

    avl_cmd_t          cmd_in;
    avl_cmd_t          head;
    logic              in_ready;
    logic              head_valid;
    logic              head_ready;
    logic [PEND_W-1:0] head_eff;
    logic [PEND_W:0]   need;
    logic              rd_hold;
    logic              rd_issue;
    logic              wr_issue;
    logic              rd_pop;
    logic              rsp_dec;
    logic [PEND_W-1:0] pend_q;
    logic [PEND_W-1:0] pend_d;
    logic              err_q;

    // A simultaneous rdena/wrena is illegal; treating it as a write keeps the data.
    always_comb begin
        cmd_in           = '0;
        cmd_in.wr        = s_avl.wrena;
        cmd_in.rd        = s_avl.rdena & ~s_avl.wrena;
        cmd_in.addr      = s_avl.addr;
        cmd_in.byteen    = s_avl.byteen;
        cmd_in.burst_cnt = s_avl.burst_cnt;
        cmd_in.wrdata    = s_avl.wrdata;
    end

    eth_avl_skid_buf #(
        .entry_t (avl_cmd_t)
    ) u_skid (
        .clk       (avl_clock),
        .rst       (avl_rst),
        .in_valid  (s_avl.rdena | s_avl.wrena),
        .in_ready  (in_ready),
        .in_data   (cmd_in),
        .out_valid (head_valid),
        .out_ready (head_ready),
        .out_data  (head)
    );

    assign s_avl.wrq = ~in_ready;

    // The held head read stalls everything behind it, preserving command order.
    assign head_eff   = eff_burst(head.burst_cnt);
    assign need       = {1'b0, pend_q} + {1'b0, head_eff};
    assign rd_hold    = head.rd & (need > (PEND_W + 1)'(pMAX_PEND));
    assign rd_issue   = head_valid & head.rd & ~rd_hold;
    assign wr_issue   = head_valid & head.wr;
    assign head_ready = (head.wr | (head.rd & ~rd_hold)) & ~m_avl.wrq;
    assign rd_pop     = rd_issue & ~m_avl.wrq;

    assign m_avl.rdena     = rd_issue;
    assign m_avl.wrena     = wr_issue;
    assign m_avl.addr      = head.addr;
    assign m_avl.byteen    = head.byteen;
    assign m_avl.burst_cnt = head.burst_cnt;
    assign m_avl.wrdata    = head.wrdata;

    // A beat with nothing outstanding is flagged but never drives the counter negative.
    assign rsp_dec = m_avl.rddataval & (pend_q != '0);

    always_comb begin
        pend_d = pend_q + (rd_pop ? head_eff : '0) - PEND_W'(rsp_dec);
    end

    always_ff @(posedge avl_clock or posedge avl_rst) begin
        if (avl_rst) begin
            pend_q <= '0;
            err_q  <= 1'b0;
        end else begin
            pend_q <= pend_d;
            if (m_avl.rddataval && pend_q == '0) begin
                err_q <= 1'b1;
            end
        end
    end

    assign pend_cnt      = pend_q;
    assign err_underflow = err_q;

`ifdef ETH_AVL_BRIDGE_RSP_REG_EN
    logic [AVL_DATA_W-1:0] rddata_q;
    logic                  rddataval_q;

    always_ff @(posedge avl_clock or posedge avl_rst) begin
        if (avl_rst) begin
            rddata_q    <= '0;
            rddataval_q <= 1'b0;
        end else begin
            rddata_q    <= m_avl.rddata;
            rddataval_q <= m_avl.rddataval;
        end
    end

    assign s_avl.rddata    = rddata_q;
    assign s_avl.rddataval = rddataval_q;
`else
    assign s_avl.rddata    = m_avl.rddata;
    assign s_avl.rddataval = m_avl.rddataval;
`endif

endmodule

// File: tb/tb_eth_avl_pipe_bridge.sv
// Directed bench for eth_avl_pipe_bridge: writes, back-pressure, read limiter,
// counter arithmetic, underflow flag and mid-operation reset.
module tb_eth_avl_pipe_bridge;
    import eth_avl_bridge_pkg::*;

    localparam int unsigned AW   = 32;
    localparam int unsigned DW   = 64;
    localparam int unsigned BW   = 8;
    localparam int unsigned MAXP = 8;

    logic        avl_clock = 1'b0;
    logic        avl_rst   = 1'b1;
    logic [15:0] pend_cnt;
    logic        err_underflow;

    int n_checks = 0;
    int n_fail   = 0;

    eth_avl_pipe_bridge_if #(.ADDR_W(AW), .DATA_W(DW), .BURST_W(BW)) s_bus ();
    eth_avl_pipe_bridge_if #(.ADDR_W(AW), .DATA_W(DW), .BURST_W(BW)) m_bus ();

    eth_avl_pipe_bridge #(
        .pADDR_WIDTH  (AW),
        .pDATA_WIDTH  (DW),
        .pBURST_WIDTH (BW),
        .pMAX_PEND    (MAXP)
    ) dut (
        .avl_clock     (avl_clock),
        .avl_rst       (avl_rst),
        .s_avl         (s_bus),
        .m_avl         (m_bus),
        .pend_cnt      (pend_cnt),
        .err_underflow (err_underflow)
    );

    always #5 avl_clock = ~avl_clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge avl_clock);
        #1;
    endtask

    task automatic s_idle();
        s_bus.rdena     = 1'b0;
        s_bus.wrena     = 1'b0;
        s_bus.addr      = '0;
        s_bus.byteen    = '0;
        s_bus.burst_cnt = '0;
        s_bus.wrdata    = '0;
    endtask

    task automatic s_cmd(input logic rd, input logic wr, input logic [31:0] a,
                         input logic [7:0] be, input logic [63:0] d, input logic [7:0] b);
        s_bus.rdena     = rd;
        s_bus.wrena     = wr;
        s_bus.addr      = a;
        s_bus.byteen    = be;
        s_bus.wrdata    = d;
        s_bus.burst_cnt = b;
    endtask

    task automatic test_reset();
        s_idle();
        m_bus.wrq       = 1'b0;
        m_bus.rddata    = '0;
        m_bus.rddataval = 1'b0;
        avl_rst = 1'b1;
        #2;
        n_checks++;
        if (s_bus.wrq !== 1'b0) begin
            n_fail++; $display("FAIL reset_s_wrq: got %b want 0", s_bus.wrq);
        end
        n_checks++;
        if (m_bus.rdena !== 1'b0 || m_bus.wrena !== 1'b0) begin
            n_fail++; $display("FAIL reset_m_ena: got rd=%b wr=%b want 0 0", m_bus.rdena, m_bus.wrena);
        end
        n_checks++;
        if (m_bus.addr !== '0 || m_bus.wrdata !== '0 || m_bus.byteen !== '0 || m_bus.burst_cnt !== '0) begin
            n_fail++; $display("FAIL reset_m_fields: got addr=%h data=%h be=%h b=%h want all 0",
                               m_bus.addr, m_bus.wrdata, m_bus.byteen, m_bus.burst_cnt);
        end
        n_checks++;
        if (pend_cnt !== 16'd0 || err_underflow !== 1'b0 || s_bus.rddataval !== 1'b0) begin
            n_fail++; $display("FAIL reset_status: got pend=%0d err=%b val=%b want 0 0 0",
                               pend_cnt, err_underflow, s_bus.rddataval);
        end
        tick();
        avl_rst = 1'b0;
        tick();
    endtask

    task automatic test_single_write();
        s_cmd(1'b0, 1'b1, 32'h100, 8'hFF, 64'hDEADBEEF_CAFEF00D, 8'd1);
        tick();
        s_idle();
        n_checks++;
        if (m_bus.wrena !== 1'b1 || m_bus.rdena !== 1'b0) begin
            n_fail++; $display("FAIL wr_single_ena: got wr=%b rd=%b want 1 0", m_bus.wrena, m_bus.rdena);
        end
        n_checks++;
        if (m_bus.addr !== 32'h100 || m_bus.wrdata !== 64'hDEADBEEF_CAFEF00D ||
            m_bus.byteen !== 8'hFF || m_bus.burst_cnt !== 8'd1) begin
            n_fail++; $display("FAIL wr_single_fields: got addr=%h data=%h be=%h b=%h want 100 deadbeefcafef00d ff 1",
                               m_bus.addr, m_bus.wrdata, m_bus.byteen, m_bus.burst_cnt);
        end
        n_checks++;
        if (s_bus.wrq !== 1'b0) begin
            n_fail++; $display("FAIL wr_single_wrq: got %b want 0", s_bus.wrq);
        end
        tick();
        n_checks++;
        if (m_bus.wrena !== 1'b0) begin
            n_fail++; $display("FAIL wr_single_once: got wr=%b want 0", m_bus.wrena);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] got_addr [8];
        logic [63:0] got_data [8];
        int          sent = 0;
        int          ngot = 0;
        logic        accept_now;
        for (int c = 0; c < 30; c++) begin
            m_bus.wrq = (c < 5);
            if (sent < 4) begin
                s_cmd(1'b0, 1'b1, 32'h200 + 32'(sent * 8), 8'h0F, 64'h1111_0000_0000_0000 + 64'(sent), 8'd1);
            end else begin
                s_idle();
            end
            accept_now = (sent < 4) && (s_bus.wrq == 1'b0);
            if (m_bus.wrena && !m_bus.wrq) begin
                if (ngot < 8) begin
                    got_addr[ngot] = m_bus.addr;
                    got_data[ngot] = m_bus.wrdata;
                end
                ngot++;
            end
            if (c == 2) begin
                n_checks++;
                if (s_bus.wrq !== 1'b1) begin
                    n_fail++; $display("FAIL bp_wrq_full: got %b want 1", s_bus.wrq);
                end
            end
            if (c == 4) begin
                n_checks++;
                if (sent !== 2) begin
                    n_fail++; $display("FAIL bp_accepted: got %0d want 2", sent);
                end
            end
            tick();
            if (accept_now) sent++;
        end
        n_checks++;
        if (ngot !== 4) begin
            n_fail++; $display("FAIL bp_count: got %0d writes want 4", ngot);
        end
        for (int i = 0; i < 4 && i < ngot; i++) begin
            n_checks++;
            if (got_addr[i] !== 32'h200 + 32'(i * 8) || got_data[i] !== 64'h1111_0000_0000_0000 + 64'(i)) begin
                n_fail++; $display("FAIL bp_order[%0d]: got addr=%h data=%h want %h %h", i, got_addr[i],
                                   got_data[i], 32'h200 + 32'(i * 8), 64'h1111_0000_0000_0000 + 64'(i));
            end
        end
        m_bus.wrq = 1'b0;
    endtask

    task automatic test_limiter();
        m_bus.wrq = 1'b0;
        s_cmd(1'b1, 1'b0, 32'h400, 8'hFF, '0, 8'd8);
        tick();
        s_cmd(1'b1, 1'b0, 32'h500, 8'hFF, '0, 8'd1);
        n_checks++;
        if (m_bus.rdena !== 1'b1 || m_bus.addr !== 32'h400 || m_bus.burst_cnt !== 8'd8) begin
            n_fail++; $display("FAIL lim_first_issue: got rd=%b addr=%h b=%0d want 1 400 8",
                               m_bus.rdena, m_bus.addr, m_bus.burst_cnt);
        end
        tick();
        s_idle();
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (m_bus.rdena !== 1'b0 || pend_cnt !== 16'd8) begin
                n_fail++; $display("FAIL lim_hold[%0d]: got rd=%b pend=%0d want 0 8", i, m_bus.rdena, pend_cnt);
            end
            tick();
        end
        m_bus.rddata    = 64'h0;
        m_bus.rddataval = 1'b1;
        n_checks++;
        if (m_bus.rdena !== 1'b0) begin
            n_fail++; $display("FAIL lim_hold_at_rsp: got rd=%b want 0", m_bus.rdena);
        end
        tick();
        m_bus.rddataval = 1'b0;
        n_checks++;
        if (pend_cnt !== 16'd7 || m_bus.rdena !== 1'b1 || m_bus.addr !== 32'h500) begin
            n_fail++; $display("FAIL lim_release: got pend=%0d rd=%b addr=%h want 7 1 500",
                               pend_cnt, m_bus.rdena, m_bus.addr);
        end
        tick();
        n_checks++;
        if (pend_cnt !== 16'd8 || m_bus.rdena !== 1'b0) begin
            n_fail++; $display("FAIL lim_second_count: got pend=%0d rd=%b want 8 0", pend_cnt, m_bus.rdena);
        end
        for (int i = 0; i < 8; i++) begin
            m_bus.rddataval = 1'b1;
            tick();
            m_bus.rddataval = 1'b0;
            n_checks++;
            if (pend_cnt !== 16'(7 - i)) begin
                n_fail++; $display("FAIL lim_drain[%0d]: got pend=%0d want %0d", i, pend_cnt, 7 - i);
            end
        end
        n_checks++;
        if (err_underflow !== 1'b0) begin
            n_fail++; $display("FAIL lim_no_err: got err=%b want 0", err_underflow);
        end
    endtask

    task automatic test_simultaneous();
        s_cmd(1'b1, 1'b0, 32'h600, 8'hFF, '0, 8'd3);
        tick();
        s_cmd(1'b1, 1'b0, 32'h680, 8'hFF, '0, 8'd4);
        tick();
        s_idle();
        n_checks++;
        if (pend_cnt !== 16'd3 || m_bus.rdena !== 1'b1 || m_bus.burst_cnt !== 8'd4) begin
            n_fail++; $display("FAIL sim_setup: got pend=%0d rd=%b b=%0d want 3 1 4",
                               pend_cnt, m_bus.rdena, m_bus.burst_cnt);
        end
        m_bus.rddataval = 1'b1;
        tick();
        m_bus.rddataval = 1'b0;
        n_checks++;
        if (pend_cnt !== 16'd6) begin
            n_fail++; $display("FAIL sim_net: got pend=%0d want 6", pend_cnt);
        end
        for (int i = 0; i < 6; i++) begin
            m_bus.rddataval = 1'b1;
            tick();
        end
        m_bus.rddataval = 1'b0;
        n_checks++;
        if (pend_cnt !== 16'd0 || err_underflow !== 1'b0) begin
            n_fail++; $display("FAIL sim_drain: got pend=%0d err=%b want 0 0", pend_cnt, err_underflow);
        end
    endtask

    task automatic test_underflow();
        m_bus.rddata    = 64'hA5A5_0000_1234_5678;
        m_bus.rddataval = 1'b1;
`ifndef ETH_AVL_BRIDGE_RSP_REG_EN
        n_checks++;
        if (s_bus.rddataval !== 1'b1 || s_bus.rddata !== 64'hA5A5_0000_1234_5678) begin
            n_fail++; $display("FAIL uf_forward: got val=%b data=%h want 1 a5a5000012345678",
                               s_bus.rddataval, s_bus.rddata);
        end
`endif
        tick();
        m_bus.rddataval = 1'b0;
`ifdef ETH_AVL_BRIDGE_RSP_REG_EN
        n_checks++;
        if (s_bus.rddataval !== 1'b1 || s_bus.rddata !== 64'hA5A5_0000_1234_5678) begin
            n_fail++; $display("FAIL uf_forward: got val=%b data=%h want 1 a5a5000012345678",
                               s_bus.rddataval, s_bus.rddata);
        end
`endif
        n_checks++;
        if (err_underflow !== 1'b1 || pend_cnt !== 16'd0) begin
            n_fail++; $display("FAIL uf_set: got err=%b pend=%0d want 1 0", err_underflow, pend_cnt);
        end
        tick(); tick(); tick();
        n_checks++;
        if (err_underflow !== 1'b1) begin
            n_fail++; $display("FAIL uf_sticky: got err=%b want 1", err_underflow);
        end
        avl_rst = 1'b1;
        #2;
        n_checks++;
        if (err_underflow !== 1'b0) begin
            n_fail++; $display("FAIL uf_clear: got err=%b want 0", err_underflow);
        end
        @(posedge avl_clock);
        #1;
        avl_rst = 1'b0;
        tick();
    endtask

    task automatic test_mid_reset();
        m_bus.wrq = 1'b0;
        s_cmd(1'b1, 1'b0, 32'h800, 8'hFF, '0, 8'd5);
        tick();
        s_idle();
        tick();
        m_bus.wrq = 1'b1;
        s_cmd(1'b0, 1'b1, 32'h700, 8'hFF, 64'h77, 8'd1);
        tick();
        s_cmd(1'b0, 1'b1, 32'h708, 8'hFF, 64'h78, 8'd1);
        tick();
        s_idle();
        n_checks++;
        if (s_bus.wrq !== 1'b1 || pend_cnt !== 16'd5 || m_bus.wrena !== 1'b1) begin
            n_fail++; $display("FAIL mr_setup: got wrq=%b pend=%0d wr=%b want 1 5 1",
                               s_bus.wrq, pend_cnt, m_bus.wrena);
        end
        #2;
        avl_rst = 1'b1;
        #1;
        n_checks++;
        if (s_bus.wrq !== 1'b0 || m_bus.wrena !== 1'b0 || m_bus.rdena !== 1'b0 ||
            m_bus.addr !== '0 || m_bus.wrdata !== '0) begin
            n_fail++; $display("FAIL mr_outputs: got wrq=%b wr=%b rd=%b addr=%h data=%h want 0 0 0 0 0",
                               s_bus.wrq, m_bus.wrena, m_bus.rdena, m_bus.addr, m_bus.wrdata);
        end
        n_checks++;
        if (pend_cnt !== 16'd0 || err_underflow !== 1'b0) begin
            n_fail++; $display("FAIL mr_status: got pend=%0d err=%b want 0 0", pend_cnt, err_underflow);
        end
        @(posedge avl_clock);
        #1;
        avl_rst   = 1'b0;
        m_bus.wrq = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (m_bus.wrena !== 1'b0 || m_bus.rdena !== 1'b0) begin
                n_fail++; $display("FAIL mr_flushed[%0d]: got wr=%b rd=%b want 0 0", i, m_bus.wrena, m_bus.rdena);
            end
            tick();
        end
        m_bus.rddataval = 1'b1;
        tick();
        m_bus.rddataval = 1'b0;
        n_checks++;
        if (err_underflow !== 1'b1 || pend_cnt !== 16'd0) begin
            n_fail++; $display("FAIL mr_late_rsp: got err=%b pend=%0d want 1 0", err_underflow, pend_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_back_to_back();
        test_limiter();
        test_simultaneous();
        test_underflow();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
